ift_taint_monitor: RTL and testbench
====================================

// Module: ift_taint_monitor
// PURPOSE
//  Downstream consumer of an IFT-instrumented register stage (e.g. adff/dff m_0). Samples Q and its taint vector Q_t,
//  counts tainted samples, records first-taint time and a per-bit sticky taint mask, and raises an alarm at a threshold.
//  Optional event log FIFO holds {timestamp, Q, Q_t} per tainted sample for bench/host readout.
// PARAMETERS
//  DW      2   data width of monitored Q
//  TW      32  taint vector width of Q_t
//  CW      16  width of timestamp and taint counter
//  DEPTH   4   event FIFO entries (power of 2, >=2)
//  THRESH  3   tainted-sample count that triggers ALARM (1..2^CW-1)
// PORTS
//  CLK        in   1    single clock, rising edge
//  SRST       in   1    synchronous reset, active-high
//  Q          in   DW   monitored data
//  Q_t        in   TW   taint of Q; nonzero = tainted
//  VLD        in   1    sample strobe; Q/Q_t evaluated only when 1
//  CLR        in   1    clear alarm/counters/log (sync, one-cycle pulse or level)
//  EV_RDY     in   1    consumer ready for event pop
//  EV_VLD     out  1    event FIFO non-empty
//  EV_TS      out  CW   head entry timestamp
//  EV_Q       out  DW   head entry data
//  EV_T       out  TW   head entry taint
//  OVF        out  1    sticky: tainted sample dropped because FIFO full
//  TS         out  CW   free-running cycle timestamp
//  TAINT_CNT  out  CW   count of tainted samples
//  FIRST_TS   out  CW   TS of first tainted sample since reset/CLR
//  STICKY_T   out  TW   OR of all sampled Q_t since reset/CLR
//  STATE      out  2    FSM state
//  ALARM      out  1    registered, =1 iff STATE==ALARM
// BEHAVIOUR
//  - Reset (SRST=1 at CLK edge): every output 0, FIFO empty, STATE=ARMED(2'b00). SRST beats CLR and all inputs.
//  - Tainted sample: VLD==1 && |Q_t. All registers updated at the edge where sampled; outputs show it next cycle.
//  - TS: +1 every cycle, wraps 2^CW-1 -> 0; not affected by CLR.
//  - TAINT_CNT: +1 per tainted sample, saturates at 2^CW-1 (no wrap).
//  - STICKY_T |= Q_t on every VLD cycle. FIRST_TS loaded with current TS on first tainted sample only while ARMED.
//  - FSM (cnt_nx = TAINT_CNT incremented): ARMED(00) --tainted--> TAINTED(01), or directly ALARM if cnt_nx>=THRESH;
//    TAINTED(01) --tainted && cnt_nx>=THRESH--> ALARM(10); ALARM holds until CLR. Code 2'b11 unused -> ARMED.
//  - CLR: next cycle STATE=ARMED, TAINT_CNT/FIRST_TS/STICKY_T/OVF=0, FIFO flushed. CLR with tainted sample in same
//    cycle: CLR wins, sample discarded entirely.
//  - FIFO: push {TS,Q,Q_t} on tainted sample; show-ahead head on EV_*; pop on EV_VLD&&EV_RDY. EV_VLD rises the cycle
//    after first push. Full & push & no pop: push dropped, OVF<=1. Full & push & pop: both occur, count unchanged.
//    Empty: EV_VLD=0, EV_TS/EV_Q/EV_T=0; EV_RDY ignored. Pointers wrap modulo DEPTH.
// CONFIGURATION
//  IFT_MON_EVLOG_EN defined: event FIFO as above.
//  Not defined: no FIFO storage; EV_VLD, EV_TS, EV_Q, EV_T, OVF tied 0; EV_RDY unused; ports remain present.
//  All other behaviour identical in both builds.
// TESTING
//  1. SRST=1 two cycles, random Q/Q_t/VLD -> all outputs 0, STATE=00, EV_VLD=0.
//  2. VLD=1, Q=2'b01, Q_t=0 for 10 cycles -> STATE=00, TAINT_CNT=0, STICKY_T=0, TS=10.
//  3. Q_t=32'h1 sampled at TS=5, then Q_t=32'h4 at TS=7,8 (THRESH=3) -> FIRST_TS=5, STATE 01 after TS=5,
//     10 after TS=8, ALARM=1, TAINT_CNT=3, STICKY_T=32'h5.
//  4. In ALARM, CLR=1 together with Q_t=32'h2, VLD=1 -> next cycle STATE=00, ALARM=0, TAINT_CNT=0, STICKY_T=0,
//     EV_VLD=0; TS keeps counting.
//  5. (EVLOG_EN, DEPTH=4) 6 tainted samples, EV_RDY=0 -> EV_VLD=1, OVF=1; then EV_RDY=1 -> 4 pops with EV_TS
//     equal to first 4 sample timestamps in order, then EV_VLD=0. Without macro -> EV_VLD, OVF stay 0.
//  6. CW=4: run 20 cycles -> TS wraps 15->0 (TS=4); 18 tainted samples -> TAINT_CNT holds 15.

Source files
------------

// File: rtl/ift_taint_monitor.sv
// ift_taint_monitor: observes an IFT-instrumented register output (Q, Q_t).
// It counts tainted samples, records the timestamp of the first tainted sample
// and a sticky per-bit taint mask, and raises ALARM once the count reaches THRESH.
// Optional feature macro: IFT_MON_EVLOG_EN adds an event FIFO of {TS, Q, Q_t}.
// Ports:
//   CLK, SRST         clock, synchronous active-high reset
//   Q, Q_t, VLD       monitored data, its taint vector, sample strobe
//   CLR               clears alarm, counters and log (TS keeps running)
//   EV_RDY            event pop request
//   EV_VLD/TS/Q/T     show-ahead FIFO head (zero when empty)
//   OVF               sticky FIFO-overflow flag
//   TS                free-running timestamp
//   TAINT_CNT         saturating tainted-sample count
//   FIRST_TS          TS of the first tainted sample while ARMED
//   STICKY_T          OR of every sampled Q_t
//   STATE, ALARM      FSM state and alarm flag
module ift_taint_monitor #(
  parameter int unsigned DW     = 2,
  parameter int unsigned TW     = 32,
  parameter int unsigned CW     = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned THRESH = 3
) (
  input  logic          CLK,
  input  logic          SRST,
  input  logic [DW-1:0] Q,
  input  logic [TW-1:0] Q_t,
  input  logic          VLD,
  input  logic          CLR,
  input  logic          EV_RDY,
  output logic          EV_VLD,
  output logic [CW-1:0] EV_TS,
  output logic [DW-1:0] EV_Q,
  output logic [TW-1:0] EV_T,
  output logic          OVF,
  output logic [CW-1:0] TS,
  output logic [CW-1:0] TAINT_CNT,
  output logic [CW-1:0] FIRST_TS,
  output logic [TW-1:0] STICKY_T,
  output logic [1:0]    STATE,
  output logic          ALARM
);

  localparam logic [1:0] ST_ARMED   = 2'b00;
  localparam logic [1:0] ST_TAINTED = 2'b01;
  localparam logic [1:0] ST_ALARM   = 2'b10;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] THR     = CW'(THRESH);

  logic [1:0]    state_q, state_d;
  logic          alarm_q;
  logic [CW-1:0] ts_q, ts_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_nx;
  logic [CW-1:0] first_q, first_d;
  logic [TW-1:0] sticky_q, sticky_d;
  logic          tainted;
  logic          take;

  // A tainted sample coinciding with CLR is discarded entirely.
  assign tainted = VLD && (|Q_t);
  assign take    = tainted && !CLR;
  assign cnt_nx  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);

  // FSM register
  always_ff @(posedge CLK) begin
    if (SRST) begin
      state_q <= ST_ARMED;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alarm_q <= (state_d == ST_ALARM);
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARMED:   if (take) state_d = (cnt_nx >= THR) ? ST_ALARM : ST_TAINTED;
      ST_TAINTED: if (take && (cnt_nx >= THR)) state_d = ST_ALARM;
      ST_ALARM:   state_d = ST_ALARM;
      default:    state_d = ST_ARMED;
    endcase
    if (CLR) state_d = ST_ARMED;
  end

  // Timestamp, counter, first-taint time and sticky mask next values
  always_comb begin
    ts_d     = ts_q + CW'(1);
    cnt_d    = cnt_q;
    first_d  = first_q;
    sticky_d = sticky_q;
    if (CLR) begin
      cnt_d    = '0;
      first_d  = '0;
      sticky_d = '0;
    end else begin
      if (VLD) sticky_d = sticky_q | Q_t;
      if (take) begin
        cnt_d = cnt_nx;
        if (state_q == ST_ARMED) first_d = ts_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (SRST) begin
      ts_q     <= '0;
      cnt_q    <= '0;
      first_q  <= '0;
      sticky_q <= '0;
    end else begin
      ts_q     <= ts_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      sticky_q <= sticky_d;
    end
  end

  assign TS        = ts_q;
  assign TAINT_CNT = cnt_q;
  assign FIRST_TS  = first_q;
  assign STICKY_T  = sticky_q;
  assign STATE     = state_q;
  assign ALARM     = alarm_q;

`ifdef IFT_MON_EVLOG_EN
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] mem_ts [DEPTH];
  logic [DW-1:0] mem_q  [DEPTH];
  logic [TW-1:0] mem_t  [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   fcnt_q, fcnt_d;
  logic          ovf_q;
  logic          ev_vld_c, full_c, pop_c, push_c, drop_c;

  assign ev_vld_c = (fcnt_q != '0);
  assign full_c   = (fcnt_q == (AW+1)'(DEPTH));
  assign pop_c    = ev_vld_c && EV_RDY;
  // When full, a push is accepted only if a pop frees a slot in the same cycle.
  assign push_c   = take && (!full_c || pop_c);
  assign drop_c   = take && full_c && !pop_c;

  always_comb begin
    fcnt_d = fcnt_q;
    case ({push_c, pop_c})
      2'b10:   fcnt_d = fcnt_q + (AW+1)'(1);
      2'b01:   fcnt_d = fcnt_q - (AW+1)'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  // Storage has no reset; entries are only visible while counted
  always_ff @(posedge CLK) begin
    if (push_c) begin
      mem_ts[wr_q] <= ts_q;
      mem_q[wr_q]  <= Q;
      mem_t[wr_q]  <= Q_t;
    end
  end

  always_ff @(posedge CLK) begin
    if (SRST || CLR) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_c) wr_q <= wr_q + AW'(1);
      if (pop_c)  rd_q <= rd_q + AW'(1);
      fcnt_q <= fcnt_d;
      if (drop_c) ovf_q <= 1'b1;
    end
  end

  assign EV_VLD = ev_vld_c;
  assign EV_TS  = ev_vld_c ? mem_ts[rd_q] : '0;
  assign EV_Q   = ev_vld_c ? mem_q[rd_q]  : '0;
  assign EV_T   = ev_vld_c ? mem_t[rd_q]  : '0;
  assign OVF    = ovf_q;
`else
  logic unused_evlog;
  assign unused_evlog = ^{Q, EV_RDY};

  assign EV_VLD = 1'b0;
  assign EV_TS  = '0;
  assign EV_Q   = '0;
  assign EV_T   = '0;
  assign OVF    = 1'b0;
`endif

endmodule

// File: tb/tb_ift_taint_monitor.sv
// Bench for ift_taint_monitor: directed scenarios plus randomized traffic,
// all checked against a queue-based behavioural model of the monitor.
module tb_ift_taint_monitor;

  typedef struct packed {
    logic [15:0] ts;
    logic [1:0]  q;
    logic [31:0] t;
  } ev_t;

  logic        CLK = 1'b0;
  logic        SRST, VLD, CLR, EV_RDY;
  logic [1:0]  Q;
  logic [31:0] Q_t;

  logic        EV_VLD, OVF, ALARM;
  logic [15:0] EV_TS, TS, TAINT_CNT, FIRST_TS;
  logic [1:0]  EV_Q, STATE;
  logic [31:0] EV_T, STICKY_T;

  logic        ev_vld4, ovf4, alarm4;
  logic [3:0]  ev_ts4, ts4, cnt4, first4;
  logic [1:0]  ev_q4, state4;
  logic [31:0] ev_t4, sticky4;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [15:0] m_ts;
  int          m_cnt;
  logic [15:0] m_first;
  logic [31:0] m_sticky;
  int          m_state;
  bit          m_ovf;
  ev_t         m_fifo[$];

  ift_taint_monitor #(.DW(2), .TW(32), .CW(16), .DEPTH(4), .THRESH(3)) dut (
    .CLK(CLK), .SRST(SRST), .Q(Q), .Q_t(Q_t), .VLD(VLD), .CLR(CLR), .EV_RDY(EV_RDY),
    .EV_VLD(EV_VLD), .EV_TS(EV_TS), .EV_Q(EV_Q), .EV_T(EV_T), .OVF(OVF), .TS(TS),
    .TAINT_CNT(TAINT_CNT), .FIRST_TS(FIRST_TS), .STICKY_T(STICKY_T), .STATE(STATE), .ALARM(ALARM)
  );

  ift_taint_monitor #(.DW(2), .TW(32), .CW(4), .DEPTH(4), .THRESH(3)) dut4 (
    .CLK(CLK), .SRST(SRST), .Q(Q), .Q_t(Q_t), .VLD(VLD), .CLR(CLR), .EV_RDY(EV_RDY),
    .EV_VLD(ev_vld4), .EV_TS(ev_ts4), .EV_Q(ev_q4), .EV_T(ev_t4), .OVF(ovf4), .TS(ts4),
    .TAINT_CNT(cnt4), .FIRST_TS(first4), .STICKY_T(sticky4), .STATE(state4), .ALARM(alarm4)
  );

  always #5 CLK = ~CLK;

  task automatic model_step();
    bit tainted;
    logic [15:0] ts_old;
    tainted = VLD && (Q_t != 0);
    ts_old  = m_ts;
    if (SRST) begin
      m_ts = 0; m_cnt = 0; m_first = 0; m_sticky = 0; m_state = 0; m_ovf = 0;
      m_fifo.delete();
    end else begin
      m_ts = m_ts + 16'd1;
      if (CLR) begin
        m_cnt = 0; m_first = 0; m_sticky = 0; m_state = 0; m_ovf = 0;
        m_fifo.delete();
      end else begin
        if (VLD) m_sticky = m_sticky | Q_t;
`ifdef IFT_MON_EVLOG_EN
        begin
          bit pop;
          pop = (m_fifo.size() > 0) && EV_RDY;
          if (pop) void'(m_fifo.pop_front());
          if (tainted) begin
            if (m_fifo.size() < 4) m_fifo.push_back('{ts: ts_old, q: Q, t: Q_t});
            else m_ovf = 1;
          end
        end
`endif
        if (tainted) begin
          if (m_state == 0) m_first = ts_old;
          if (m_cnt < 65535) m_cnt++;
          if (m_state == 0) m_state = (m_cnt >= 3) ? 2 : 1;
          else if (m_state == 1 && m_cnt >= 3) m_state = 2;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    SRST = 0; VLD = 0; CLR = 0; EV_RDY = 0; Q = 0; Q_t = 0;
  endtask

  task automatic test_reset();
    SRST = 1;
    for (int i = 0; i < 2; i++) begin
      VLD = 1'($urandom); Q = 2'($urandom); Q_t = $urandom; CLR = 1'($urandom); EV_RDY = 1'($urandom);
      tick();
    end
    n_vec++; if (TS !== 16'd0) begin n_err++; $display("FAIL reset_ts got %0d exp 0", TS); end
    n_vec++; if (TAINT_CNT !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", TAINT_CNT); end
    n_vec++; if (FIRST_TS !== 16'd0) begin n_err++; $display("FAIL reset_first got %0d exp 0", FIRST_TS); end
    n_vec++; if (STICKY_T !== 32'd0) begin n_err++; $display("FAIL reset_sticky got %h exp 0", STICKY_T); end
    n_vec++; if (STATE !== 2'b00) begin n_err++; $display("FAIL reset_state got %b exp 00", STATE); end
    n_vec++; if (ALARM !== 1'b0) begin n_err++; $display("FAIL reset_alarm got %b exp 0", ALARM); end
    n_vec++; if (EV_VLD !== 1'b0 || OVF !== 1'b0) begin n_err++; $display("FAIL reset_ev got vld=%b ovf=%b exp 0 0", EV_VLD, OVF); end
    n_vec++; if (EV_TS !== 16'd0 || EV_Q !== 2'd0 || EV_T !== 32'd0) begin n_err++; $display("FAIL reset_head got %h %h %h exp 0", EV_TS, EV_Q, EV_T); end
    idle_inputs();
  endtask

  task automatic test_clean();
    VLD = 1; Q = 2'b01; Q_t = 0;
    for (int i = 0; i < 10; i++) tick();
    n_vec++; if (STATE !== 2'b00) begin n_err++; $display("FAIL clean_state got %b exp 00", STATE); end
    n_vec++; if (TAINT_CNT !== 16'd0) begin n_err++; $display("FAIL clean_cnt got %0d exp 0", TAINT_CNT); end
    n_vec++; if (STICKY_T !== 32'd0) begin n_err++; $display("FAIL clean_sticky got %h exp 0", STICKY_T); end
    n_vec++; if (TS !== 16'd10) begin n_err++; $display("FAIL clean_ts got %0d exp 10", TS); end
    idle_inputs();
  endtask

  task automatic test_threshold();
    SRST = 1; tick(); idle_inputs();
    for (int i = 0; i < 5; i++) tick();
    VLD = 1; Q = 2'b10; Q_t = 32'h1; tick();
    n_vec++; if (STATE !== 2'b01) begin n_err++; $display("FAIL thr_state1 got %b exp 01", STATE); end
    n_vec++; if (FIRST_TS !== 16'd5) begin n_err++; $display("FAIL thr_first got %0d exp 5", FIRST_TS); end
    VLD = 0; tick();
    VLD = 1; Q_t = 32'h4; tick();
    n_vec++; if (STATE !== 2'b01 || TAINT_CNT !== 16'd2) begin n_err++; $display("FAIL thr_mid got st=%b cnt=%0d exp 01 2", STATE, TAINT_CNT); end
    tick();
    n_vec++; if (STATE !== 2'b10) begin n_err++; $display("FAIL thr_state2 got %b exp 10", STATE); end
    n_vec++; if (ALARM !== 1'b1) begin n_err++; $display("FAIL thr_alarm got %b exp 1", ALARM); end
    n_vec++; if (TAINT_CNT !== 16'd3) begin n_err++; $display("FAIL thr_cnt got %0d exp 3", TAINT_CNT); end
    n_vec++; if (STICKY_T !== 32'h5) begin n_err++; $display("FAIL thr_sticky got %h exp 5", STICKY_T); end
    n_vec++; if (FIRST_TS !== 16'd5) begin n_err++; $display("FAIL thr_first_hold got %0d exp 5", FIRST_TS); end
    idle_inputs();
  endtask

  task automatic test_clr();
    logic [15:0] ts_exp;
    ts_exp = TS + 16'd1;
    CLR = 1; VLD = 1; Q_t = 32'h2; Q = 2'b11; tick();
    n_vec++; if (STATE !== 2'b00 || ALARM !== 1'b0) begin n_err++; $display("FAIL clr_state got st=%b al=%b exp 00 0", STATE, ALARM); end
    n_vec++; if (TAINT_CNT !== 16'd0 || FIRST_TS !== 16'd0) begin n_err++; $display("FAIL clr_cnt got cnt=%0d first=%0d exp 0 0", TAINT_CNT, FIRST_TS); end
    n_vec++; if (STICKY_T !== 32'd0) begin n_err++; $display("FAIL clr_sticky got %h exp 0", STICKY_T); end
    n_vec++; if (EV_VLD !== 1'b0) begin n_err++; $display("FAIL clr_evvld got %b exp 0", EV_VLD); end
    n_vec++; if (TS !== ts_exp) begin n_err++; $display("FAIL clr_ts got %0d exp %0d", TS, ts_exp); end
    idle_inputs();
  endtask

  task automatic test_fifo();
    logic [15:0] exp_ts[6];
    logic [1:0]  exp_q[6];
    logic [31:0] exp_t[6];
    bit          en;
`ifdef IFT_MON_EVLOG_EN
    en = 1;
`else
    en = 0;
`endif
    SRST = 1; tick(); idle_inputs();
    for (int i = 0; i < 6; i++) begin
      VLD = 1; Q = 2'($urandom); Q_t = $urandom | 32'h100;
      exp_ts[i] = m_ts; exp_q[i] = Q; exp_t[i] = Q_t;
      tick();
      if (i == 0) begin
        n_vec++; if (EV_VLD !== en) begin n_err++; $display("FAIL fifo_first_vld got %b exp %b", EV_VLD, en); end
      end
    end
    idle_inputs();
    n_vec++; if (EV_VLD !== en) begin n_err++; $display("FAIL fifo_vld got %b exp %b", EV_VLD, en); end
    n_vec++; if (OVF !== en) begin n_err++; $display("FAIL fifo_ovf got %b exp %b", OVF, en); end
    EV_RDY = 1;
    for (int i = 0; i < 4; i++) begin
      if (en) begin
        n_vec++; if (EV_VLD !== 1'b1 || EV_TS !== exp_ts[i]) begin n_err++; $display("FAIL fifo_pop%0d got vld=%b ts=%0d exp 1 %0d", i, EV_VLD, EV_TS, exp_ts[i]); end
        n_vec++; if (EV_Q !== exp_q[i] || EV_T !== exp_t[i]) begin n_err++; $display("FAIL fifo_data%0d got %h %h exp %h %h", i, EV_Q, EV_T, exp_q[i], exp_t[i]); end
      end else begin
        n_vec++; if (EV_VLD !== 1'b0 || EV_TS !== 16'd0) begin n_err++; $display("FAIL fifo_off%0d got vld=%b ts=%0d exp 0 0", i, EV_VLD, EV_TS); end
      end
      tick();
    end
    n_vec++; if (EV_VLD !== 1'b0) begin n_err++; $display("FAIL fifo_drained got %b exp 0", EV_VLD); end
    n_vec++; if (EV_TS !== 16'd0 || EV_T !== 32'd0) begin n_err++; $display("FAIL fifo_empty_head got %h %h exp 0", EV_TS, EV_T); end
    n_vec++; if (OVF !== en) begin n_err++; $display("FAIL fifo_ovf_sticky got %b exp %b", OVF, en); end
    idle_inputs();
  endtask

  task automatic test_random();
    ev_t h;
    SRST = 1; tick(); idle_inputs();
    for (int i = 0; i < 400; i++) begin
      SRST   = ($urandom_range(0, 99) < 2);
      CLR    = ($urandom_range(0, 99) < 6);
      VLD    = 1'($urandom);
      EV_RDY = ($urandom_range(0, 99) < 40);
      Q      = 2'($urandom);
      Q_t    = ($urandom_range(0, 2) == 0) ? 32'd0 : (32'd1 << $urandom_range(0, 31));
      tick();
      h = (m_fifo.size() > 0) ? m_fifo[0] : '0;
      n_vec++; if (TS !== m_ts) begin n_err++; $display("FAIL rnd_ts@%0d got %0d exp %0d", i, TS, m_ts); end
      n_vec++; if (TAINT_CNT !== 16'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt@%0d got %0d exp %0d", i, TAINT_CNT, m_cnt); end
      n_vec++; if (FIRST_TS !== m_first) begin n_err++; $display("FAIL rnd_first@%0d got %0d exp %0d", i, FIRST_TS, m_first); end
      n_vec++; if (STICKY_T !== m_sticky) begin n_err++; $display("FAIL rnd_sticky@%0d got %h exp %h", i, STICKY_T, m_sticky); end
      n_vec++; if (STATE !== 2'(m_state) || ALARM !== (m_state == 2)) begin n_err++; $display("FAIL rnd_state@%0d got %b/%b exp %0d", i, STATE, ALARM, m_state); end
      n_vec++; if (EV_VLD !== (m_fifo.size() > 0) || OVF !== m_ovf) begin n_err++; $display("FAIL rnd_evflags@%0d got %b %b exp %0d %b", i, EV_VLD, OVF, m_fifo.size(), m_ovf); end
      n_vec++; if (EV_TS !== h.ts || EV_Q !== h.q || EV_T !== h.t) begin n_err++; $display("FAIL rnd_head@%0d got %h %h %h exp %h %h %h", i, EV_TS, EV_Q, EV_T, h.ts, h.q, h.t); end
    end
    idle_inputs();
  endtask

  task automatic test_narrow_wrap();
    SRST = 1; tick(); idle_inputs();
    for (int i = 0; i < 20; i++) tick();
    n_vec++; if (ts4 !== 4'd4) begin n_err++; $display("FAIL wrap_ts got %0d exp 4", ts4); end
    VLD = 1; Q_t = 32'h8;
    for (int i = 0; i < 18; i++) tick();
    n_vec++; if (cnt4 !== 4'd15) begin n_err++; $display("FAIL wrap_cnt_sat got %0d exp 15", cnt4); end
    n_vec++; if (ts4 !== 4'((20 + 18) % 16)) begin n_err++; $display("FAIL wrap_ts2 got %0d exp %0d", ts4, (20 + 18) % 16); end
    n_vec++; if (state4 !== 2'b10 || first4 !== 4'd4) begin n_err++; $display("FAIL wrap_state got %b first=%0d exp 10 4", state4, first4); end
    n_vec++; if (TAINT_CNT !== 16'd18) begin n_err++; $display("FAIL wide_cnt got %0d exp 18", TAINT_CNT); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_ts = 0; m_cnt = 0; m_first = 0; m_sticky = 0; m_state = 0; m_ovf = 0;
    @(posedge CLK); #1;
    test_reset();
    test_clean();
    test_threshold();
    test_clr();
    test_fifo();
    test_random();
    test_narrow_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
